// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//   Buffers 8-bit ALU results ({zero, s, carry, y}) in a small FIFO. Consumers
//   drain the entries at their own rate through a valid/ready handshake.
//
//   Optional feature macro: ALU_RESULT_FIFO_DROP_CNT_EN
//     defined   : drop_cnt counts cycles where a push was offered but refused
//                 (in_valid && !in_ready, not in reset, not flushing).
//                 It saturates at 255 and is cleared only by reset.
//     undefined : drop_cnt is tied to 0.
//
//   Ports
//     clk, rst_n        clock, synchronous active-low reset
//     flush             clears all buffered entries on the next edge
//     in_valid/in_ready producer handshake; in_y/in_carry/in_s is the payload
//     out_valid/out_ready consumer handshake; out_y/out_carry/out_s/out_zero
//                       is the head entry, driven to 0 when the FIFO is empty
//     count             entries held, 0..DEPTH
//     drop_cnt          refused-push counter (see above)
// -----------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_y,
    input  logic          in_carry,
    input  logic [2:0]    in_s,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_y,
    output logic          out_carry,
    output logic [2:0]    out_s,
    output logic          out_zero,
    output logic [AW:0]   count,
    output logic [7:0]    drop_cnt
);

    typedef struct packed {
        logic       zero;
        logic [2:0] s;
        logic       carry;
        logic [7:0] y;
    } entry_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    entry_t [DEPTH-1:0] mem_q, mem_d;
    logic   [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic   [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic   [AW:0]      count_q, count_d;
    logic               push, pop;
    entry_t             head;

    // in_ready never looks at out_ready: a full FIFO refuses a push even
    // when a pop happens in the same cycle.
    assign in_ready  = rst_n && (count_q != FULL);
    assign out_valid = (count_q != '0);

    // Flush wins over both handshakes; a push in a flush cycle is discarded.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign head      = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_y     = head.y;
    assign out_carry = head.carry;
    assign out_s     = head.s;
    assign out_zero  = head.zero;
    assign count     = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{zero: (in_y == 8'd0), s: in_s, carry: in_carry, y: in_y};
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; push is already blocked while rst_n is low.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (in_valid && !in_ready && !flush && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, in_carry;
    logic [7:0]    in_y;
    logic [2:0]    in_s;
    logic          out_valid, out_ready, out_carry, out_zero;
    logic [7:0]    out_y;
    logic [2:0]    out_s;
    logic [AW:0]   count;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    alu_result_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .in_carry(in_carry), .in_s(in_s),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_carry(out_carry), .out_s(out_s), .out_zero(out_zero),
        .count(count), .drop_cnt(drop_cnt)
    );

    // Reference model: a plain queue of accepted results plus a drop tally.
    typedef struct {
        logic [7:0] y;
        logic       c;
        logic [2:0] s;
    } ent_t;

    ent_t q[$];
    int   drop_m = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_model();
        logic [7:0] ey;
        logic       ec, ez;
        logic [2:0] es;
        ey = 8'd0; ec = 1'b0; es = 3'd0; ez = 1'b0;
        if (q.size() != 0) begin
            ey = q[0].y; ec = q[0].c; es = q[0].s; ez = (q[0].y == 8'd0);
        end
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("out_y",     32'(out_y),     32'(ey));
        chk("out_carry", 32'(out_carry), 32'(ec));
        chk("out_s",     32'(out_s),     32'(es));
        chk("out_zero",  32'(out_zero),  32'(ez));
        chk("count",     32'(count),     32'(q.size()));
        chk("in_ready",  32'(in_ready),  32'(rst_n && (q.size() != DEPTH)));
        chk("drop_cnt",  32'(drop_cnt),  32'(drop_m));
    endtask

    // One clock: drive inputs, advance the model, sample 1ns after the edge.
    task automatic cycle(input logic v, input logic [7:0] y, input logic c, input logic [2:0] s,
                         input logic rdy, input logic fl, input logic rs);
        bit acc;
        bit pp;
        rst_n = rs; flush = fl; in_valid = v; in_y = y; in_carry = c; in_s = s; out_ready = rdy;
        acc = (q.size() != DEPTH);
        pp  = (q.size() != 0) && rdy;
        if (!rs) begin
            q.delete();
            drop_m = 0;
        end else if (fl) begin
            q.delete();
        end else begin
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
            if (v && !acc && drop_m < 255) drop_m++;
`endif
            if (pp) void'(q.pop_front());
            if (v && acc) q.push_back('{y: y, c: c, s: s});
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic push(input logic [7:0] y, input logic c, input logic [2:0] s);
        cycle(1'b1, y, c, s, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pop();
        cycle(1'b0, 8'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        bit         hold;
        logic       v, rdy, fl, rs, c;
        logic [7:0] y;
        logic [2:0] s;

        // Reset held two cycles with a push offered.
        cycle(1'b1, 8'd55, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'd55, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        cycle(1'b0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Single pass.
        push(8'd20, 1'b0, 3'd0);
        chk("single_y", 32'(out_y), 32'd20);
        chk("single_count", 32'(count), 32'd1);
        pop();
        chk("single_empty", 32'(out_valid), 32'd0);

        // Fill, order and wrap.
        for (int i = 1; i <= 4; i++) push(8'(i), 1'b0, 3'd3);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_ready", 32'(in_ready), 32'd0);
        pop();
        pop();
        push(8'd5, 1'b0, 3'd4);
        push(8'd6, 1'b0, 3'd4);
        for (int i = 3; i <= 6; i++) begin
            chk("wrap_order", 32'(out_y), 32'(i));
            pop();
        end

        // Full plus a refused push with a simultaneous pop.
        for (int i = 10; i < 14; i++) push(8'(i), 1'b1, 3'd5);
        cycle(1'b1, 8'd99, 1'b0, 3'd6, 1'b1, 1'b0, 1'b1);
        chk("full_drop_count", 32'(count), 32'd3);
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
        chk("full_drop_cnt", 32'(drop_cnt), 32'd1);
`else
        chk("full_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        pop();
        pop();
        pop();

        // Zero and carry capture.
        push(8'd0, 1'b1, 3'd1);
        chk("zero_flag", 32'(out_zero), 32'd1);
        chk("zero_carry", 32'(out_carry), 32'd1);
        chk("zero_s", 32'(out_s), 32'd1);
        pop();

        // Flush beats a same-cycle push.
        for (int i = 0; i < 3; i++) push(8'(40 + i), 1'b0, 3'd2);
        cycle(1'b1, 8'd7, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        push(8'd7, 1'b0, 3'd0);
        chk("post_flush_y", 32'(out_y), 32'd7);

        // Randomized traffic with occasional flush and mid-operation reset.
        hold = 0;
        v = 0; y = 0; c = 0; s = 0;
        for (int i = 0; i < 400; i++) begin
            rs  = ($urandom_range(59) != 0);
            fl  = ($urandom_range(19) == 0);
            rdy = (i < 200) ? ($urandom_range(2) == 0) : ($urandom_range(2) != 0);
            if (!hold) begin
                v = 1'($urandom_range(1));
                y = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom);
                c = 1'($urandom_range(1));
                s = 3'($urandom_range(7));
            end
            hold = v && rs && !fl && (q.size() == DEPTH);
            cycle(v, y, c, s, rdy, fl, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the 8-bit ALU: captures each ALU result (y, carry, with the op select s that produced it) and buffers it in a small FIFO.
- Consumers such as the display/logging stage or the next datapath stage drain results at their own rate through a valid/ready handshake.
- Adds a zero flag per entry so consumers need not re-derive it.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous clear of all buffered entries.
- in_valid  input  1  ALU result presented this cycle.
- in_ready  output  1  FIFO can accept a result this cycle.
- in_y  input  8  ALU result y.
- in_carry  input  1  ALU carry.
- in_s  input  3  ALU op select that produced the result.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head entry.
- out_y  output  8  head entry result.
- out_carry  output  1  head entry carry.
- out_s  output  3  head entry op select.
- out_zero  output  1  head entry (y == 8'd0).
- count  output  AW+1  number of entries held, 0..DEPTH.
- drop_cnt  output  8  dropped-write counter (see Optional Feature).

Behaviour:
- Entry format: {zero, s, carry, y}, 13 bits. Zero is computed from in_y at write time.
- Push: in_valid && in_ready. Entry is written at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: out_valid && out_ready. rd_ptr increments modulo DEPTH.
- in_ready = rst_n && (count != DEPTH). It does not depend combinationally on out_ready, so a full FIFO rejects a push even if a pop happens in the same cycle.
- out_valid = (count != 0).
- out_* are driven from mem[rd_ptr] when out_valid = 1, and forced to 0 when out_valid = 0.
- Latency: a push into an empty FIFO gives out_valid = 1 on the next cycle. There is no same-cycle fall-through.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Full (count == DEPTH): in_ready = 0. in_valid is ignored, so data is lost unless the producer holds it.
- Empty: out_ready is ignored, and pointers and count do not change.
- Pointer wrap: DEPTH-1 wraps to 0. Behaviour is identical across wrap.
- flush = 1 (rst_n = 1): on the next edge wr_ptr = rd_ptr = count = 0. Flush has priority over push and pop in the same cycle; a push in that cycle is discarded. Memory contents are not cleared.
- Reset (rst_n = 0 at a clock edge), including mid-operation: wr_ptr = rd_ptr = count = 0, drop_cnt = 0, out_valid = 0, out_* = 0, in_ready = 0 while rst_n is low. Reset has priority over flush, push and pop. Memory contents are not cleared.
- Producer rule: in_y, in_carry and in_s must stay stable while in_valid = 1 and in_ready = 0.

Optional Feature:
- Macro: ALU_RESULT_FIFO_DROP_CNT_EN.
- Defined: drop_cnt increments by 1 on each cycle with in_valid = 1 and in_ready = 0 and rst_n = 1 and flush = 0. It saturates at 8'd255 and is cleared only by reset.
- Not defined: drop_cnt is tied to 8'd0 and no counter logic is generated.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 -> in_ready = 0, out_valid = 0, count = 0, out_y = 0, drop_cnt = 0. Release -> in_ready = 1.
- Single pass: push y = 20, carry = 0, s = 000 -> next cycle out_valid = 1, out_y = 20, out_s = 000, out_zero = 0, count = 1. Pop -> count = 0, out_valid = 0.
- Fill, order and wrap: push y = 1, 2, 3, 4 with out_ready = 0 -> count = 4, in_ready = 0. Pop two, push 5, 6 -> pops return 3, 4, 5, 6 in order across pointer wrap.
- Full plus drop: with count = 4, assert in_valid with y = 99 and out_ready = 1 -> one pop occurs, 99 is not written, count = 3. With ALU_RESULT_FIFO_DROP_CNT_EN, drop_cnt = 1; without it, drop_cnt = 0.
- Zero/carry capture: push y = 0, carry = 1, s = 001 (10-10 subtract) -> out_zero = 1, out_carry = 1, out_s = 001.
- Flush versus push: count = 3, assert flush and a push of y = 7 in the same cycle -> next cycle count = 0, out_valid = 0. A push on the following cycle yields out_y = 7 after one cycle.
